alu_fsm: RTL and testbench
==========================

# alu_fsm

Condition-code state machine for the processor's branch unit. Tracks the N/Z/P status of the last value the ALU wrote to the register file, and decides whether a conditional branch is taken by matching the stored (or concurrently written) condition against the instruction's decoded n/z/p mask. It sits between the ALU, the instruction decoder and the PC-select mux; `pc_ctl_0_out` drives bit 0 of the PC control.

## Interface

One clock; reset is synchronous and active-low.

- No parameters.
- `clka`  in  1  system clock; all state updates occur on its rising edge.
- `reset_in`  in  1  synchronous active-low reset (0 = reset).
- `n_dec_in`  in  1  decoded branch mask bit: branch if negative.
- `z_dec_in`  in  1  decoded branch mask bit: branch if zero.
- `p_dec_in`  in  1  decoded branch mask bit: branch if positive.
- `n_alu_in`  in  1  ALU result negative flag.
- `z_alu_in`  in  1  ALU result zero flag.
- `p_alu_in`  in  1  ALU result positive flag.
- `we_reg_in`  in  1  register-file write enable; qualifies the ALU flags as the new condition.
- `br_in`  in  1  current instruction is a conditional branch.
- `pc_ctl_0_out`  out  1  branch taken (combinational).
- `state_out`  out  3  current state as {N,Z,P}, one-hot or 000.

## Operation

- States and their `state_out` encodings:
  - IDLE = 000
  - N = 100
  - Z = 010
  - P = 001
- Candidate next state `nxt`:
  - `we_reg_in`=1: priority encode the ALU flags, with N over Z over P. `n_alu_in` gives N; else `z_alu_in` gives Z; else `p_alu_in` gives P.
  - `we_reg_in`=1 with all ALU flags 0: `nxt` = current state (hold).
  - `we_reg_in`=0: `nxt` = current state. ALU flags are ignored.
- Transitions on the rising edge of `clka`:
  - `reset_in`=0: state <= IDLE. Reset overrides `we_reg_in`.
  - Otherwise: state <= `nxt`.
- Any state can reach N, Z or P directly. IDLE is reached only through reset.
- Branch decision uses the bypassed condition `eff` = `nxt`:
  - `pc_ctl_0_out` = `reset_in` & `br_in` & ((`eff`[2] & `n_dec_in`) | (`eff`[1] & `z_dec_in`) | (`eff`[0] & `p_dec_in`)).
  - Because of the bypass, a branch in the same cycle as a flag-setting write sees the new flags.
- In IDLE, `eff` is 000 unless a write is occurring, so no branch is taken regardless of the dec mask.
- Multiple dec bits may be set (e.g. nzp = 111). The branch is taken if any set bit matches.

## Timing

- `state_out` is registered and updates one `clka` edge after `we_reg_in`/flags are presented.
- `pc_ctl_0_out` is purely combinational from inputs and state, with zero-cycle latency. It is valid before the next rising edge and forced to 0 while `reset_in`=0.
- Reset values:
  - `state_out` = 000 after the first edge with `reset_in`=0.
  - `pc_ctl_0_out` = 0.
- Before the first reset, the state is don't-care. The bench must reset first.
- Reset during a write cycle: reset wins, and the state goes to IDLE.
- Flag pulses with `we_reg_in`=0 never change the state.

## Test plan

- Reset, then pulse `n_alu_in`, `z_alu_in`, `p_alu_in` one at a time with `we_reg_in`=0 -> `state_out` stays 000 and `pc_ctl_0_out`=0 throughout.
- Write-driven transitions, with `we_reg_in`=1 for each write:
  - `n_alu_in`=1 -> `state_out`=100 after the edge.
  - Then `z_alu_in`=1 -> 010.
  - Then `p_alu_in`=1 -> 001.
  - Dropping `we_reg_in` holds the state across further flag toggles.
- Stored-condition branch:
  - state N (100), `we_reg_in`=0, `br_in`=1, `n_dec_in`=1 -> `pc_ctl_0_out`=1.
  - Repeat for Z with `z_dec_in` and P with `p_dec_in` -> 1.
  - Same with `br_in`=0 -> 0.
- Bypass, from state P:
  - `we_reg_in`=1, `n_alu_in`=1, `n_dec_in`=1, `br_in`=1 -> `pc_ctl_0_out`=1 in the same cycle, and `state_out`=100 after the edge.
  - Then `p_alu_in`=1, `p_dec_in`=1 -> 1.
  - Then `z_alu_in`=1, `z_dec_in`=1 -> 1.
- Mismatch, with `we_reg_in`=1 and `br_in`=1:
  - `n_alu_in`=1 with dec z,p=1 -> 0.
  - `p_alu_in`=1 with `n_dec_in`=1 -> 0.
  - `z_alu_in`=1 with `n_dec_in`,`p_dec_in`=1 -> 0.
- Reset mid-run from state Z:
  - `reset_in`=0 for one edge -> `state_out`=000.
  - Then `br_in`=1 with all dec bits=1 and `we_reg_in`=0 for two cycles -> `pc_ctl_0_out`=0.

Source files
------------

// File: rtl/alu_fsm.sv
// -----------------------------------------------------------------------------
// alu_fsm
// Condition-code state machine for the branch unit. Remembers the N/Z/P status
// of the last value the ALU wrote to the register file and decides whether a
// conditional branch is taken. The decision matches the instruction's n/z/p
// mask against the stored condition, or against the condition being written
// in the same cycle, so a branch right after a compare needs no stall.
//
// Ports
//   clka          in   system clock, rising edge
//   reset_in      in   synchronous active-low reset (0 = reset)
//   n_dec_in      in   branch mask: take if negative
//   z_dec_in      in   branch mask: take if zero
//   p_dec_in      in   branch mask: take if positive
//   n_alu_in      in   ALU result negative flag
//   z_alu_in      in   ALU result zero flag
//   p_alu_in      in   ALU result positive flag
//   we_reg_in     in   register-file write enable; qualifies the ALU flags
//   br_in         in   current instruction is a conditional branch
//   pc_ctl_0_out  out  branch taken (combinational), PC control bit 0
//   state_out     out  current condition as {N,Z,P}; one-hot, or 000 in IDLE
// -----------------------------------------------------------------------------
module alu_fsm (
  input  logic       clka,
  input  logic       reset_in,
  input  logic       n_dec_in,
  input  logic       z_dec_in,
  input  logic       p_dec_in,
  input  logic       n_alu_in,
  input  logic       z_alu_in,
  input  logic       p_alu_in,
  input  logic       we_reg_in,
  input  logic       br_in,
  output logic       pc_ctl_0_out,
  output logic [2:0] state_out
);

  // State encodings double as the {N,Z,P} condition vector.
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] ST_N = 3'b100;
  localparam logic [2:0] ST_Z = 3'b010;
  localparam logic [2:0] ST_P = 3'b001;

  logic [2:0] state;
  logic [2:0] nxt;

  // Candidate next state. A write with all flags clear keeps the old
  // condition rather than falling back to IDLE; IDLE is reachable only by reset.
  always_comb begin
    // NOTE: default assignment first so every path drives nxt and no latch is inferred.
    nxt = state;
    if (we_reg_in) begin
      if (n_alu_in)      nxt = ST_N;
      else if (z_alu_in) nxt = ST_Z;
      else if (p_alu_in) nxt = ST_P;
    end
  end

  always_ff @(posedge clka) begin
    // NOTE: non-blocking assignments for registered state avoid ordering races between always blocks.
    if (!reset_in) state <= IDLE;
    else           state <= nxt;
  end

  // Branch decision uses nxt as a bypass of the state register, so a branch
  // issued alongside a flag-setting write sees the new flags.
  assign pc_ctl_0_out = reset_in & br_in &
                        |(nxt & {n_dec_in, z_dec_in, p_dec_in});

  assign state_out = state;

endmodule

// File: tb/tb_alu_fsm.sv
module tb_alu_fsm;

  logic       clka = 1'b0;
  logic       reset_in = 1'b0;
  logic       n_dec_in = 1'b0, z_dec_in = 1'b0, p_dec_in = 1'b0;
  logic       n_alu_in = 1'b0, z_alu_in = 1'b0, p_alu_in = 1'b0;
  logic       we_reg_in = 1'b0;
  logic       br_in = 1'b0;
  logic       pc_ctl_0_out;
  logic [2:0] state_out;

  alu_fsm dut (
    .clka         (clka),
    .reset_in     (reset_in),
    .n_dec_in     (n_dec_in),
    .z_dec_in     (z_dec_in),
    .p_dec_in     (p_dec_in),
    .n_alu_in     (n_alu_in),
    .z_alu_in     (z_alu_in),
    .p_alu_in     (p_alu_in),
    .we_reg_in    (we_reg_in),
    .br_in        (br_in),
    .pc_ctl_0_out (pc_ctl_0_out),
    .state_out    (state_out)
  );

  always #5 clka = ~clka;

  typedef struct {
    string      tag;
    logic       exp_pc;
    logic [2:0] exp_st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one cycle of inputs mid-cycle, queue what the DUT must produce,
  // then compare the combinational branch output before the edge and the
  // registered state after it.
  task automatic step(input string tag, input logic rst, input logic we,
                      input logic [2:0] alu, input logic br, input logic [2:0] dec,
                      input logic exp_pc, input logic [2:0] exp_st);
    exp_t e;
    reset_in  = rst;
    we_reg_in = we;
    {n_alu_in, z_alu_in, p_alu_in} = alu;
    br_in     = br;
    {n_dec_in, z_dec_in, p_dec_in} = dec;
    sb.push_back('{tag, exp_pc, exp_st});
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"}, {2'b00, pc_ctl_0_out}, {2'b00, e.exp_pc});
    @(posedge clka);
    #1;
    check({e.tag, ".st"}, state_out, e.exp_st);
  endtask

  initial begin
    @(negedge clka);
    //    tag          rst we alu     br dec     pc    state
    step("reset",      0, 0, 3'b000, 0, 3'b000, 1'b0, 3'b000);
    // Flag pulses without a write: no state change, no branch even with full mask.
    step("nowe_n",     1, 0, 3'b100, 1, 3'b111, 1'b0, 3'b000);
    step("nowe_z",     1, 0, 3'b010, 1, 3'b111, 1'b0, 3'b000);
    step("nowe_p",     1, 0, 3'b001, 1, 3'b111, 1'b0, 3'b000);
    // Write-driven transitions.
    step("wr_n",       1, 1, 3'b100, 0, 3'b000, 1'b0, 3'b100);
    step("wr_z",       1, 1, 3'b010, 0, 3'b000, 1'b0, 3'b010);
    step("wr_p",       1, 1, 3'b001, 0, 3'b000, 1'b0, 3'b001);
    step("hold_n",     1, 0, 3'b100, 0, 3'b000, 1'b0, 3'b001);
    step("hold_z",     1, 0, 3'b010, 0, 3'b000, 1'b0, 3'b001);
    step("wr_none",    1, 1, 3'b000, 0, 3'b000, 1'b0, 3'b001);
    // Stored-condition branches.
    step("set_n",      1, 1, 3'b100, 0, 3'b000, 1'b0, 3'b100);
    step("br_n",       1, 0, 3'b000, 1, 3'b100, 1'b1, 3'b100);
    step("set_z",      1, 1, 3'b010, 0, 3'b000, 1'b0, 3'b010);
    step("br_z",       1, 0, 3'b000, 1, 3'b010, 1'b1, 3'b010);
    step("set_p",      1, 1, 3'b001, 0, 3'b000, 1'b0, 3'b001);
    step("br_p",       1, 0, 3'b000, 1, 3'b001, 1'b1, 3'b001);
    step("br_p_nmask", 1, 0, 3'b000, 1, 3'b110, 1'b0, 3'b001);
    step("nobr",       1, 0, 3'b000, 0, 3'b111, 1'b0, 3'b001);
    // Bypass from P: the branch sees the flags written this cycle.
    step("byp_n",      1, 1, 3'b100, 1, 3'b100, 1'b1, 3'b100);
    step("byp_p",      1, 1, 3'b001, 1, 3'b001, 1'b1, 3'b001);
    step("byp_z",      1, 1, 3'b010, 1, 3'b010, 1'b1, 3'b010);
    // Mismatch between written condition and mask.
    step("mis_n",      1, 1, 3'b100, 1, 3'b011, 1'b0, 3'b100);
    step("mis_p",      1, 1, 3'b001, 1, 3'b100, 1'b0, 3'b001);
    step("mis_z",      1, 1, 3'b010, 1, 3'b101, 1'b0, 3'b010);
    // Flag priority N over Z over P.
    step("pri_nzp",    1, 1, 3'b111, 1, 3'b100, 1'b1, 3'b100);
    step("pri_zp",     1, 1, 3'b011, 1, 3'b001, 1'b0, 3'b010);
    // Reset from Z during a write: reset wins and the branch is forced off.
    step("rst_wr",     0, 1, 3'b100, 1, 3'b111, 1'b0, 3'b000);
    step("idle_br0",   1, 0, 3'b000, 1, 3'b111, 1'b0, 3'b000);
    step("idle_br1",   1, 0, 3'b000, 1, 3'b111, 1'b0, 3'b000);
    check("sb_empty", 3'(sb.size()), 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
